// File: rtl/correlator_bank.sv
// Bank of NTAPS early/prompt/late-style code correlators for I and Q arms with dump/handshake.
// Optional clamp-on-overflow of the running sums is enabled by defining CORR_SAT_EN.
module correlator_bank #(
    parameter int NTAPS   = 3,
    parameter int SPACING = 2,
    parameter int ACC_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic                   hc_en,
    input  logic                   code_in,
    input  logic                   mix_i_sign,
    input  logic                   mix_q_sign,
    input  logic [2:0]             mix_i_mag,
    input  logic [2:0]             mix_q_mag,
    input  logic                   dump_en,
    input  logic                   rd_ack,
    output logic [NTAPS*ACC_W-1:0] acc_i,
    output logic [NTAPS*ACC_W-1:0] acc_q,
    output logic                   dump_ready,
    output logic                   missed_dump,
    output logic                   overflow,
    output logic [7:0]             dump_cnt
);

    localparam int SR_W = NTAPS * SPACING;

`ifdef CORR_SAT_EN
    // Symmetric clamp: the most negative code is never produced.
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;
`endif

    logic [SR_W-1:0]          r_sr;
    logic signed [ACC_W-1:0]  r_sum_i [NTAPS];
    logic signed [ACC_W-1:0]  r_sum_q [NTAPS];
    logic [NTAPS*ACC_W-1:0]   r_acc_i;
    logic [NTAPS*ACC_W-1:0]   r_acc_q;
    logic                     r_sat_seen;
    logic                     r_overflow;
    logic                     r_dump_ready;
    logic                     r_missed;
    logic [7:0]               r_dump_cnt;

    logic [ACC_W:0]           w_step_i [NTAPS];
    logic [ACC_W:0]           w_step_q [NTAPS];
    logic                     w_sat_any;

    // One accumulate step; returns {saturated, next_sum}.
    function automatic logic [ACC_W:0] acc_step(
        input logic signed [ACC_W-1:0] sum,
        input logic                    en,
        input logic                    sign,
        input logic                    tap,
        input logic [2:0]              mag
    );
        logic signed [ACC_W:0]   prod;
        logic signed [ACC_W:0]   wide;
        logic signed [ACC_W-1:0] nxt;
        logic                    sat;
        // NOTE: blocking assignments are correct here; these are combinational temporaries.
        prod = $signed({{(ACC_W-2){1'b0}}, mag});
        if (sign != tap) prod = -prod;
        if (!en)         prod = '0;
        wide = $signed({sum[ACC_W-1], sum}) + prod;
        nxt  = wide[ACC_W-1:0];
        sat  = 1'b0;
`ifdef CORR_SAT_EN
        if (wide > SAT_MAX) begin
            nxt = SAT_MAX[ACC_W-1:0];
            sat = 1'b1;
        end else if (wide < SAT_MIN) begin
            nxt = SAT_MIN[ACC_W-1:0];
            sat = 1'b1;
        end
`endif
        return {sat, nxt};
    endfunction

    // Taps read the delay line before any same-cycle shift.
    always_comb begin
        w_sat_any = 1'b0;
        for (int k = 0; k < NTAPS; k++) begin
            w_step_i[k] = acc_step(r_sum_i[k], sample_en, mix_i_sign, r_sr[k*SPACING], mix_i_mag);
            w_step_q[k] = acc_step(r_sum_q[k], sample_en, mix_q_sign, r_sr[k*SPACING], mix_q_mag);
            w_sat_any   = w_sat_any | w_step_i[k][ACC_W] | w_step_q[k][ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the running sums are a small register array, not a RAM, so resetting them is cheap and required.
            r_sr         <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                r_sum_i[k] <= '0;
                r_sum_q[k] <= '0;
            end
            r_acc_i      <= '0;
            r_acc_q      <= '0;
            r_sat_seen   <= 1'b0;
            r_overflow   <= 1'b0;
            r_dump_ready <= 1'b0;
            r_missed     <= 1'b0;
            r_dump_cnt   <= '0;
        end else begin
            if (hc_en) r_sr <= SR_W'({r_sr, code_in});

            for (int k = 0; k < NTAPS; k++) begin
                if (dump_en) begin
                    r_acc_i[k*ACC_W +: ACC_W] <= w_step_i[k][ACC_W-1:0];
                    r_acc_q[k*ACC_W +: ACC_W] <= w_step_q[k][ACC_W-1:0];
                    r_sum_i[k]                <= '0;
                    r_sum_q[k]                <= '0;
                end else begin
                    r_sum_i[k] <= w_step_i[k][ACC_W-1:0];
                    r_sum_q[k] <= w_step_q[k][ACC_W-1:0];
                end
            end

            if (dump_en) begin
                r_overflow <= r_sat_seen | w_sat_any;
                r_sat_seen <= 1'b0;
                r_dump_cnt <= r_dump_cnt + 8'd1;
            end else begin
                r_sat_seen <= r_sat_seen | w_sat_any;
            end

            // A dump always wins over a coincident acknowledge.
            r_dump_ready <= dump_en | (r_dump_ready & ~rd_ack);
            r_missed     <= ~rd_ack & (r_missed | (dump_en & r_dump_ready));
        end
    end

    assign acc_i       = r_acc_i;
    assign acc_q       = r_acc_q;
    assign dump_ready  = r_dump_ready;
    assign missed_dump = r_missed;
    assign overflow    = r_overflow;
    assign dump_cnt    = r_dump_cnt;

endmodule

// File: tb/tb_correlator_bank.sv
// Directed self-checking bench for correlator_bank: a default-width instance and an ACC_W=8
// instance share stimulus; expected saturation results follow CORR_SAT_EN.
module tb_correlator_bank;

    logic clk = 1'b0;
    logic rst, sample_en, hc_en, code_in, mix_i_sign, mix_q_sign, dump_en, rd_ack;
    logic [2:0] mix_i_mag, mix_q_mag;

    logic [47:0] acc_i, acc_q;
    logic        dump_ready, missed_dump, overflow;
    logic [7:0]  dump_cnt;

    logic [23:0] acc_i8, acc_q8;
    logic        dump_ready8, missed_dump8, overflow8;
    logic [7:0]  dump_cnt8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_cnt  = '0;

    always #5 clk = ~clk;

    correlator_bank #(.NTAPS(3), .SPACING(2), .ACC_W(16)) u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .hc_en(hc_en), .code_in(code_in),
        .mix_i_sign(mix_i_sign), .mix_q_sign(mix_q_sign), .mix_i_mag(mix_i_mag), .mix_q_mag(mix_q_mag),
        .dump_en(dump_en), .rd_ack(rd_ack), .acc_i(acc_i), .acc_q(acc_q),
        .dump_ready(dump_ready), .missed_dump(missed_dump), .overflow(overflow), .dump_cnt(dump_cnt)
    );

    correlator_bank #(.NTAPS(3), .SPACING(2), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .hc_en(hc_en), .code_in(code_in),
        .mix_i_sign(mix_i_sign), .mix_q_sign(mix_q_sign), .mix_i_mag(mix_i_mag), .mix_q_mag(mix_q_mag),
        .dump_en(dump_en), .rd_ack(rd_ack), .acc_i(acc_i8), .acc_q(acc_q8),
        .dump_ready(dump_ready8), .missed_dump(missed_dump8), .overflow(overflow8), .dump_cnt(dump_cnt8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tap16(input logic [47:0] v, input int k);
        return v[k*16 +: 16];
    endfunction

    function automatic logic [7:0] tap8(input logic [23:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    // One clock with the given strobes; outputs are sampled 1 ns after the edge.
    task automatic cycle(input logic s_en, input logic h_en, input logic c_in,
                         input logic d_en, input logic ack);
        sample_en = s_en; hc_en = h_en; code_in = c_in; dump_en = d_en; rd_ack = ack;
        @(posedge clk); #1;
        sample_en = 1'b0; hc_en = 1'b0; code_in = 1'b0; dump_en = 1'b0; rd_ack = 1'b0;
        if (d_en) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_en = 1'b1; hc_en = 1'b1; code_in = 1'b1; dump_en = 1'b1; rd_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; sample_en = 1'b0; hc_en = 1'b0; code_in = 1'b0; dump_en = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic fill_sr(input logic bit_val);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, bit_val, 1'b0, 1'b0);
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [15:0] exp16;
    logic [7:0]  exp_pos8, exp_neg8;
    logic        exp_ovf8;

    initial begin
        rst = 1'b0; sample_en = 1'b0; hc_en = 1'b0; code_in = 1'b0; dump_en = 1'b0; rd_ack = 1'b0;
        mix_i_sign = 1'b0; mix_q_sign = 1'b0; mix_i_mag = '0; mix_q_mag = '0;
`ifdef CORR_SAT_EN
        exp_pos8 = 8'h7F; exp_neg8 = 8'h81; exp_ovf8 = 1'b1;
`else
        exp_pos8 = 8'h8C; exp_neg8 = 8'h74; exp_ovf8 = 1'b0;
`endif

        // Reset with every strobe asserted
        mix_i_sign = 1'b1; mix_i_mag = 3'd7;
        do_reset();
        check("rst_acc_i", acc_i[31:0], 32'h0);
        check("rst_acc_i_hi", {16'h0, acc_i[47:32]}, 32'h0);
        check("rst_acc_q", acc_q[31:0], 32'h0);
        check("rst_ready", dump_ready, 1'b0);
        check("rst_missed", missed_dump, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_cnt", dump_cnt, 8'd0);

        // Accumulate: sr all ones, I +3 x10, Q -2 x10
        fill_sr(1'b1);
        mix_i_sign = 1'b1; mix_i_mag = 3'd3; mix_q_sign = 1'b0; mix_q_mag = 3'd2;
        samples(10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("acc_i_tap%0d", k), tap16(acc_i, k), 16'd30);
            check($sformatf("acc_q_tap%0d", k), tap16(acc_q, k), 16'hFFEC);
        end
        check("acc8_i_tap0", tap8(acc_i8, 0), 8'd30);
        check("acc_ready", dump_ready, 1'b1);
        check("acc_missed", missed_dump, 1'b0);
        check("acc_cnt", dump_cnt, exp_cnt);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_ready", dump_ready, 1'b0);
        mix_i_mag = 3'd1;
        samples(1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("period2_i_tap0", tap16(acc_i, 0), 16'd1);
        check("period2_q_tap0", tap16(acc_q, 0), 16'hFFFE);

        // Delay line: single 1 walks through; each sample coincides with a shift and a dump
        mix_i_sign = 1'b1; mix_i_mag = 3'd1; mix_q_sign = 1'b1; mix_q_mag = 3'd2;
        fill_sr(1'b0);
        for (int n = 1; n <= 7; n++) begin
            cycle(n >= 2, n <= 6, n == 1, n >= 2, 1'b1);
            if (n >= 2) begin
                for (int k = 0; k < 3; k++) begin
                    exp16 = (2*k == n-2) ? 16'd1 : 16'hFFFF;
                    check($sformatf("dly_hc%0d_tap%0d", n-1, k), tap16(acc_i, k), exp16);
                end
            end
        end
        check("dumpack_ready", dump_ready, 1'b1);
        check("dumpack_missed", missed_dump, 1'b0);

        // Saturation: 20 samples of magnitude 7
        fill_sr(1'b1);
        mix_i_sign = 1'b1; mix_i_mag = 3'd7; mix_q_sign = 1'b0; mix_q_mag = 3'd7;
        samples(20);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            check($sformatf("sat8_i_tap%0d", k), tap8(acc_i8, k), exp_pos8);
        check("sat8_q_tap0", tap8(acc_q8, 0), exp_neg8);
        check("sat8_ovf", overflow8, exp_ovf8);
        check("sat16_i_tap0", tap16(acc_i, 0), 16'd140);
        check("sat16_q_tap0", tap16(acc_q, 0), 16'hFF74);
        check("sat16_ovf", overflow, 1'b0);
        mix_i_mag = 3'd1; mix_q_mag = 3'd1;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("sat8_next_i_tap0", tap8(acc_i8, 0), 8'd1);
        check("sat8_next_ovf", overflow8, 1'b0);

        // Handshake
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        samples(2);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hs1_ready", dump_ready, 1'b1);
        check("hs1_missed", missed_dump, 1'b0);
        check("hs1_i_tap0", tap16(acc_i, 0), 16'd2);
        samples(5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hs2_missed", missed_dump, 1'b1);
        check("hs2_ready", dump_ready, 1'b1);
        check("hs2_i_tap0", tap16(acc_i, 0), 16'd5);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hs_ack_ready", dump_ready, 1'b0);
        check("hs_ack_missed", missed_dump, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("hs_both_ready", dump_ready, 1'b1);
        check("hs_both_missed", missed_dump, 1'b0);
        check("hs_cnt", dump_cnt, exp_cnt);

        // Reset mid-period discards partial sums and clears the delay line
        samples(4);
        do_reset();
        check("midrst_ready", dump_ready, 1'b0);
        check("midrst_cnt", dump_cnt, 8'd0);
        mix_i_sign = 1'b0; mix_i_mag = 3'd1;
        samples(3);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            check($sformatf("midrst_i_tap%0d", k), tap16(acc_i, k), 16'd3);
        check("midrst_cnt1", dump_cnt, 8'd1);

        // dump_cnt wraps after 256 dumps
        for (int i = 0; i < 254; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("cnt_255", dump_cnt, 8'd255);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("cnt_wrap", dump_cnt, 8'd0);
        check("cnt_wrap_model", dump_cnt, exp_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/correlator_bank.md
CORRELATOR_BANK -- requirements
Module: correlator_bank

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- NTAPS, 3, number of code taps (>=1)
- SPACING, 2, half-chip delay between adjacent taps (>=1)
- ACC_W, 16, accumulator width, two's complement (>=8)
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous reset, active-high
- sample_en, in, 1, accumulate the current mixer sample
- hc_en, in, 1, half-chip strobe; shifts the code delay line
- code_in, in, 1, earliest code chip
- mix_i_sign / mix_q_sign, in, 1 each, mixer sign (1 = positive)
- mix_i_mag / mix_q_mag, in, 3 each, mixer magnitude, unsigned 0..7
- dump_en, in, 1, end of integration period
- rd_ack, in, 1, host has read the latched results
- acc_i / acc_q, out, NTAPS*ACC_W each, latched sums; tap k at bits [k*ACC_W +: ACC_W]
- dump_ready, out, 1, new results are available
- missed_dump, out, 1, sticky: results were overwritten before being read
- overflow, out, 1, sticky: saturation occurred in the latched period
- dump_cnt, out, 8, count of dumps, wraps

Function
REQ-003 Delay line SHALL be an NTAPS*SPACING-bit shift register sr; on hc_en, sr <= {sr[MSB-1:0], code_in}.
REQ-004 Tap k SHALL be sr[k*SPACING]; tap 0 is the earliest tap.
REQ-005 The product for each tap and arm SHALL be +mag when mix_sign == tap, and -mag otherwise.
REQ-006 On sample_en, each of the 2*NTAPS running sums SHALL add its product.
REQ-007 The product SHALL be sign-extended to ACC_W before the add.
REQ-008 On dump_en, acc_i and acc_q SHALL latch the running sums, including the same-cycle sample if sample_en=1.
REQ-009 On dump_en, the running sums SHALL clear to 0 in the same cycle.
REQ-010 The code tap used by a sample SHALL be the sr value before any same-cycle hc_en shift.
REQ-011 dump_ready SHALL set on dump_en and clear on rd_ack.
- If dump_en and rd_ack occur together, dump wins: dump_ready stays 1 and missed_dump is not set.
REQ-012 missed_dump SHALL set when dump_en occurs while dump_ready=1 and rd_ack=0.
- The outputs SHALL take the new values.
- missed_dump SHALL clear on rd_ack.
REQ-013 overflow SHALL latch on dump_en as the OR of per-period saturation events across all sums.
REQ-014 Outputs SHALL be registered: values are visible one cycle after the dump_en edge.
REQ-015 dump_cnt SHALL increment on each dump_en and wrap from 255 to 0.

Reset
REQ-016 On rst=1 at a clk edge, the following SHALL be 0 regardless of other inputs:
- sr and all running sums
- acc_i, acc_q
- dump_ready, missed_dump, overflow, dump_cnt
REQ-017 rst asserted mid-integration SHALL discard the partial sums; the first period after reset starts from 0.

Configuration
REQ-018 Macro CORR_SAT_EN SHALL control saturation.
- Defined: running sums SHALL clamp to +/-(2^(ACC_W-1)-1), and a per-period saturation flag SHALL feed overflow.
- Undefined: sums SHALL wrap modulo 2^ACC_W, and overflow SHALL be constant 0.

Verification
REQ-019 Bench (NTAPS=3, SPACING=2, ACC_W=16 unless stated) SHALL cover:
- Reset: rst 1 cycle -> all outputs 0, dump_ready=0.
- Accumulate: sr all 1s, mix_i_sign=1, mix_i_mag=3, 10 sample_en, then dump_en -> every acc_i tap = +30; dump_ready=1; next period starts at 0.
- Delay line: code_in=1 for one hc_en, then 0 -> tap0 high after hc_en #1, tap1 after #3, tap2 after #5.
- Saturation, ACC_W=8, mag 7, same sign, 20 samples:
  - CORR_SAT_EN defined -> +127, overflow=1.
  - CORR_SAT_EN undefined -> -116, overflow=0.
- Handshake: two dumps with no rd_ack -> missed_dump=1, outputs hold the second period; rd_ack -> dump_ready=0, missed_dump=0; dump_en with rd_ack together -> dump_ready=1, missed_dump=0.
- Boundaries:
  - sample_en with dump_en in the same cycle -> sample included in the latched sum.
  - rst mid-period -> next dump contains only post-reset samples.
  - 256 dumps -> dump_cnt=0.
